mem_arbiter: RTL and testbench

Two-requester access controller for the multi-cycle CPU's unified instruction/data memory. It accepts fetch requests from the PC/IR stage and load/store requests from the data stage, grants one at a time, and drives the single memory port. It returns registered read data and a one-cycle completion pulse to the winner. The arbiter sits between the CPU control unit and `mem`. It also rejects out-of-region accesses before they reach the memory.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_pick2.sv | 58 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter slice.
//   arb_state_t        : arbiter FSM states (IDLE, ACC_IF, ACC_D)
//   DATA_LIMIT_DEFAULT : first word address outside the writable data region
//   TEXT_BASE_DEFAULT  : byte base address of the instruction region
//   fetch_word_addr()  : maps a fetch byte address into the unified word space
//                        (range checking only; the memory sees the raw address)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_D  = 2'd2
    } arb_state_t;

    localparam int unsigned DATA_LIMIT_DEFAULT = 512;
    localparam logic [31:0] TEXT_BASE_DEFAULT  = 32'h0040_0000;

    // Instruction words live directly above the data words in the unified memory.
    function automatic logic [31:0] fetch_word_addr(input logic [31:0] a,
                                                    input logic [31:0] text_base,
                                                    input logic [31:0] data_limit);
        return ((a - text_base) >> 2) + data_limit;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2
// Two-way request picker used by mem_arbiter while it is idle.
// Configuration macro: ARB_RR_EN
//   defined   : round-robin; on a tie the requester not served last wins.
//               The pointer moves on every grant and resets to "data served last".
//   undefined : fixed priority, data before fetch; no state at all.
// Ports:
//   clock, resetn : clock and async active-low reset (ARB_RR_EN only)
//   grant         : a grant is being issued this cycle (ARB_RR_EN only)
//   req_if, req_d : fetch / data requests
//   pick_if, pick_d : one-hot (or zero) selection
import mem_arb_pkg::*;

module arb_pick2 (
`ifdef ARB_RR_EN
    input  logic clock,
    input  logic resetn,
    input  logic grant,
`endif
    input  logic req_if,
    input  logic req_d,
    output logic pick_if,
    output logic pick_d
);

`ifdef ARB_RR_EN
    logic last_d;

    // Remember which side was served last so a tie goes to the other one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_d <= 1'b1;
        end else if (grant) begin
            last_d <= pick_d;
        end
    end

    // Single requests win outright; a tie is broken by the pointer.
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (req_if && req_d) begin
            pick_d  = !last_d;
            pick_if = last_d;
        end else begin
            pick_d  = req_d;
            pick_if = req_if;
        end
    end
`else
    // Data accesses always take precedence over fetches.
    always_comb begin
        pick_d  = req_d;
        pick_if = req_if && !req_d;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the single unified-memory port between instruction fetch and
// data load/store, rejecting out-of-region accesses before they reach memory.
// Configuration macro: ARB_RR_EN (round-robin instead of data-first priority).
// Ports:
//   clock, resetn              : clock, async active-low reset
//   if_req/if_addr             : fetch request and byte address
//   if_gnt/if_rvalid/if_rdata/if_err : fetch grant, completion, data, error
//   d_req/d_we/d_addr/d_wdata  : data request, store flag, word address, store data
//   d_gnt/d_rvalid/d_rdata/d_err : data grant, completion, data, error
//   mem_ena_W/mem_ena_R        : memory write / read enables
//   mem_addr/mem_data_W        : memory address / write data (latched)
//   mem_data_R                 : memory read data
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int unsigned DATA_LIMIT = DATA_LIMIT_DEFAULT,
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_ena_W,
    output logic        mem_ena_R,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_W,
    input  logic [31:0] mem_data_R
);

    localparam logic [31:0] DATA_LIMIT_W = 32'(DATA_LIMIT);

    arb_state_t  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_err;
    logic        pick_if;
    logic        pick_d;
    logic [31:0] if_word;
    logic        if_addr_err;
    logic        d_addr_err;

    // Fetches must land in the text region; only stores are bounded on the data side.
    assign if_word     = fetch_word_addr(if_addr, TEXT_BASE, DATA_LIMIT_W);
    assign if_addr_err = (if_addr < TEXT_BASE) || (if_word < DATA_LIMIT_W);
    assign d_addr_err  = d_we && (d_addr >= DATA_LIMIT_W);

`ifdef ARB_RR_EN
    logic grant;

    assign grant = (state == IDLE) && (if_req || d_req);

    arb_pick2 u_pick (
        .clock   (clock),
        .resetn  (resetn),
        .grant   (grant),
        .req_if  (if_req),
        .req_d   (d_req),
        .pick_if (pick_if),
        .pick_d  (pick_d)
    );
`else
    arb_pick2 u_pick (
        .req_if  (if_req),
        .req_d   (d_req),
        .pick_if (pick_if),
        .pick_d  (pick_d)
    );
`endif

    // Enables decode straight from state so an async reset kills a pending
    // write before the memory's falling-edge commit.
    assign mem_ena_R  = (state != IDLE) && !lat_we && !lat_err;
    assign mem_ena_W  = (state == ACC_D) && lat_we && !lat_err;
    assign mem_addr   = lat_addr;
    assign mem_data_W = lat_wdata;

    // Arbiter FSM: IDLE picks and latches a winner, each ACC state lasts one
    // cycle and returns a registered response pulse on the way back to IDLE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'd0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= ACC_D;
                        d_gnt     <= 1'b1;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_we    <= d_we;
                        lat_err   <= d_addr_err;
                    end else if (pick_if) begin
                        state     <= ACC_IF;
                        if_gnt    <= 1'b1;
                        lat_addr  <= if_addr;
                        lat_wdata <= 32'd0;
                        lat_we    <= 1'b0;
                        lat_err   <= if_addr_err;
                    end
                end
                ACC_IF: begin
                    state     <= IDLE;
                    if_rvalid <= 1'b1;
                    if_err    <= lat_err;
                    if_rdata  <= lat_err ? 32'd0 : mem_data_R;
                end
                ACC_D: begin
                    state    <= IDLE;
                    d_rvalid <= 1'b1;
                    d_err    <= lat_err;
                    if (!lat_we) begin
                        d_rdata <= lat_err ? 32'd0 : mem_data_R;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a behavioural unified memory, a table
// of single accesses with their expected responses, and hand-written
// sequences for simultaneous requests and reset in the middle of a store.
import mem_arb_pkg::*;

module tb_mem_arbiter;

    localparam logic [31:0] TB_TEXT = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_ena_W;
    logic        mem_ena_R;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_W;
    logic [31:0] mem_data_R;

    int checks   = 0;
    int failures = 0;
    logic bad_write = 1'b0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        side_d;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    vec_t  vecs [12];
    resp_t sb [$];
    logic [31:0] mem [0:1023];

    mem_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_ena_W  (mem_ena_W),
        .mem_ena_R  (mem_ena_R),
        .mem_addr   (mem_addr),
        .mem_data_W (mem_data_W),
        .mem_data_R (mem_data_R)
    );

    always #5 clock = ~clock;

    // Text words sit above the 512 data words in the model's storage.
    function automatic int unsigned map_addr(input logic [31:0] a);
        logic [31:0] t;
        if (a >= TB_TEXT) begin
            t = ((a - TB_TEXT) >> 2) + 32'd512;
        end else begin
            t = a;
        end
        return int'(t[9:0]);
    endfunction

    assign mem_data_R = mem[map_addr(mem_addr)];

    // Memory commits writes on the falling edge; flag any write outside the data region.
    always @(negedge clock) begin
        if (mem_ena_W) begin
            mem[map_addr(mem_addr)] = mem_data_W;
            if (mem_addr >= 32'd512) bad_write = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        resp_t r;
        if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rvalid actual=%b%b expected=00", if_rvalid, d_rvalid);
            end else begin
                r = sb.pop_front();
                checkOutput("resp_side", {30'd0, if_rvalid, d_rvalid}, r.side_d ? 32'd1 : 32'd2);
                checkOutput("resp_err", r.side_d ? {31'd0, d_err} : {31'd0, if_err}, {31'd0, r.err});
                checkOutput("resp_rdata", r.side_d ? d_rdata : if_rdata, r.rdata);
            end
        end
    end

    // Single access: request at a falling edge, check grant and memory port
    // during the access cycle, then let the response reach the scoreboard.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        if (v.is_d) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        sb.push_back('{side_d: v.is_d, err: v.exp_err, rdata: v.exp_rdata});
        @(posedge clock);
        #1;
        checkOutput("gnt", {30'd0, if_gnt, d_gnt}, v.is_d ? 32'd1 : 32'd2);
        checkOutput("mem_ena_R", {31'd0, mem_ena_R}, {31'd0, !v.we && !v.exp_err});
        checkOutput("mem_ena_W", {31'd0, mem_ena_W}, {31'd0, v.we && !v.exp_err});
        checkOutput("mem_addr", mem_addr, v.addr);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("gnt_drop", {30'd0, if_gnt, d_gnt}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int nd;
        int ni;

        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        mem[512] = 32'h8C04_0003;
        mem[513] = 32'h2008_000A;

        vecs[0]  = '{1'b1, 1'b0, 32'd3,          32'd0,      1'b0, 32'd3};
        vecs[1]  = '{1'b0, 1'b0, 32'h0040_0000,  32'd0,      1'b0, 32'h8C04_0003};
        vecs[2]  = '{1'b1, 1'b1, 32'd2,          32'h0000_00AA, 1'b0, 32'd3};
        vecs[3]  = '{1'b1, 1'b0, 32'd2,          32'd0,      1'b0, 32'h0000_00AA};
        vecs[4]  = '{1'b1, 1'b1, 32'd600,        32'h55,     1'b1, 32'h0000_00AA};
        vecs[5]  = '{1'b1, 1'b0, 32'd600,        32'd0,      1'b0, 32'd600};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0010,  32'd0,      1'b1, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0040_0004,  32'd0,      1'b0, 32'h2008_000A};
        vecs[8]  = '{1'b1, 1'b1, 32'd511,        32'h1234,   1'b0, 32'd600};
        vecs[9]  = '{1'b1, 1'b0, 32'd511,        32'd0,      1'b0, 32'h1234};
        vecs[10] = '{1'b1, 1'b1, 32'd512,        32'hBEEF,   1'b1, 32'h1234};
        vecs[11] = '{1'b0, 1'b0, 32'h003F_FFFC,  32'd0,      1'b1, 32'd0};

        resetn  = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        checkOutput("reset_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        checkOutput("reset_err", {30'd0, if_err, d_err}, 32'd0);
        checkOutput("reset_ena", {30'd0, mem_ena_W, mem_ena_R}, 32'd0);
        checkOutput("reset_if_rdata", if_rdata, 32'd0);
        checkOutput("reset_d_rdata", d_rdata, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_data_W", mem_data_W, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
        checkOutput("if_rdata_held", if_rdata, 32'd0);

        // Both requesters held for three grants; the last grant above was a fetch.
        @(negedge clock);
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'd5;
`ifdef ARB_RR_EN
        sb.push_back('{side_d: 1'b1, err: 1'b0, rdata: 32'd5});
        sb.push_back('{side_d: 1'b0, err: 1'b0, rdata: 32'h8C04_0003});
        sb.push_back('{side_d: 1'b1, err: 1'b0, rdata: 32'd5});
`else
        for (int i = 0; i < 3; i++) sb.push_back('{side_d: 1'b1, err: 1'b0, rdata: 32'd5});
`endif
        nd = 0;
        ni = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            nd += int'(d_gnt);
            ni += int'(if_gnt);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
`ifdef ARB_RR_EN
        checkOutput("tie_d_grants", 32'(nd), 32'd2);
        checkOutput("tie_if_grants", 32'(ni), 32'd1);
`else
        checkOutput("tie_d_grants", 32'(nd), 32'd3);
        checkOutput("tie_if_grants", 32'(ni), 32'd0);
`endif
        repeat (2) @(negedge clock);

        // Reset lands in the middle of a store, before the falling-edge commit.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd7;
        d_wdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        checkOutput("store_ena_W", {31'd0, mem_ena_W}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("rst_ena_W", {31'd0, mem_ena_W}, 32'd0);
        checkOutput("rst_ena_R", {31'd0, mem_ena_R}, 32'd0);
        checkOutput("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_data_W", mem_data_W, 32'd0);
        checkOutput("rst_rdata", d_rdata | if_rdata, 32'd0);
        d_we   = 1'b0;
        d_addr = 32'd9;
        @(negedge clock);
        #1;
        checkOutput("rst_store_dropped", mem[7], 32'd7);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        sb.push_back('{side_d: 1'b1, err: 1'b0, rdata: 32'd9});
        @(posedge clock);
        #1;
        checkOutput("post_rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        d_req = 1'b0;
        repeat (3) @(negedge clock);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        checkOutput("no_out_of_range_write", {31'd0, bad_write}, 32'd0);
        checkOutput("mem600_kept", mem[600], 32'd600);
        checkOutput("mem512_kept", mem[512], 32'h8C04_0003);
        checkOutput("mem2_stored", mem[2], 32'h0000_00AA);
        checkOutput("mem511_stored", mem[511], 32'h0000_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
